// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
// Holds the FSM encoding, the default word width and the counter sizing helper.
package piso_pkg;

   localparam int WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter must hold 0..WIDTH-1; a one-bit word still needs one counter bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load handshake plus serial output bundle of piso_tx.
// master = word requester / serial consumer, slave = the transmitter itself.
interface piso_tx_if
   import piso_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) ();

   logic [WIDTH-1:0] data_in;
   logic             R_L;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             done;

   modport master (
      output data_in,
      output R_L,
      output load_valid,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  done
   );

   modport slave (
      input  data_in,
      input  R_L,
      input  load_valid,
      output load_ready,
      output sout,
      output sout_valid,
      output done
   );

endinterface

// File: rtl/dff_ar.sv
// Generic W-bit D flip-flop with asynchronous active-high clear.
// Every storage bit of piso_tx lives in one of these.
module dff_ar #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter: loads a WIDTH-bit word on handshake,
// shifts it out MSB- or LSB-first over WIDTH cycles, then pulses done.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   piso_tx_if.slave  bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state_reg;
   state_t           state_next;
   logic [1:0]       state_bits_reg;
   logic [WIDTH-1:0] sreg_reg;
   logic [WIDTH-1:0] sreg_next;
   logic [CW-1:0]    cnt_reg;
   logic [CW-1:0]    cnt_next;
   logic             dir_reg;
   logic             dir_next;

   logic             load_ready_int;
   logic             sout_int;
   logic             sout_valid_int;
   logic             done_int;

   // ------------------------------------------------------------------
   // State register process: all storage built from dff_ar instances
   // ------------------------------------------------------------------
   dff_ar #(.W(2)) u_state (
      .clk (clk),
      .rst (rst),
      .d   (state_next),
      .q   (state_bits_reg)
   );

   assign state_reg = state_t'(state_bits_reg);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sreg
         dff_ar #(.W(1)) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (sreg_next[gi]),
            .q   (sreg_reg[gi])
         );
      end
   endgenerate

   dff_ar #(.W(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .d   (cnt_next),
      .q   (cnt_reg)
   );

   dff_ar #(.W(1)) u_dir (
      .clk (clk),
      .rst (rst),
      .d   (dir_next),
      .q   (dir_reg)
   );

   // ------------------------------------------------------------------
   // Next-state process: FSM transitions and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      sreg_next  = sreg_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      case (state_reg)
         IDLE: begin
            if (bus.load_valid) begin
               sreg_next  = bus.data_in;
               dir_next   = bus.R_L;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Shift toward whichever end feeds sout, back-filling with zeros.
            sreg_next = dir_reg ? (sreg_reg >> 1) : (sreg_reg << 1);
            if (cnt_reg == CNT_LAST) begin
               cnt_next   = '0;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output process: decoded purely from registered state
   // ------------------------------------------------------------------
   always_comb begin
      load_ready_int = 1'b0;
      sout_int       = 1'b0;
      sout_valid_int = 1'b0;
      done_int       = 1'b0;
      case (state_reg)
         IDLE: begin
            load_ready_int = 1'b1;
         end
         SHIFT: begin
            sout_valid_int = 1'b1;
            sout_int       = dir_reg ? sreg_reg[0] : sreg_reg[WIDTH-1];
         end
         DONE: begin
            done_int = 1'b1;
         end
         default: begin
            load_ready_int = 1'b0;
         end
      endcase
   end

   assign bus.load_ready = load_ready_int;
   assign bus.sout       = sout_int;
   assign bus.sout_valid = sout_valid_int;
   assign bus.done       = done_int;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4): bit order, latency,
// in-flight isolation, asynchronous abort and back-to-back throughput.
module tb_piso_tx;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   piso_tx_if #(.WIDTH(W)) bus ();

   piso_tx #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word for exactly one load edge; afterwards the DUT is in cycle 1 of SHIFT.
   task automatic load_word(input logic [W-1:0] d, input logic rl);
      bus.data_in    = d;
      bus.R_L        = rl;
      bus.load_valid = 1'b1;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.data_in    = '0;
      bus.R_L        = 1'b0;
      bus.load_valid = 1'b0;
      #2;
      checks++;
      if (bus.load_ready !== 1'b1 || bus.sout_valid !== 1'b0 || bus.sout !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: ready=%b valid=%b sout=%b done=%b required 1 0 0 0",
                  bus.load_ready, bus.sout_valid, bus.sout, bus.done);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (bus.load_ready !== 1'b1 || bus.sout_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: ready=%b valid=%b required 1 0", bus.load_ready, bus.sout_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_msb_first();
      logic [W-1:0] seq;
      seq = 4'b1011;
      load_word(4'b1011, 1'b0);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (bus.sout_valid !== 1'b1 || bus.sout !== seq[W-1-i] || bus.load_ready !== 1'b0) begin
            failures++;
            $display("FAIL msb_bit%0d: valid=%b sout=%b ready=%b required 1 %b 0",
                     i, bus.sout_valid, bus.sout, bus.load_ready, seq[W-1-i]);
         end
         tick();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.sout_valid !== 1'b0 || bus.sout !== 1'b0) begin
         failures++;
         $display("FAIL msb_done: done=%b valid=%b sout=%b required 1 0 0", bus.done, bus.sout_valid, bus.sout);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.load_ready !== 1'b1) begin
         failures++;
         $display("FAIL msb_back_idle: done=%b ready=%b required 0 1", bus.done, bus.load_ready);
      end
      $display("test_msb_first word=1011 R_L=0 sent");
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] seq;
      logic [W-1:0] rx;
      seq = 4'b1101;
      rx  = '0;
      load_word(4'b1011, 1'b1);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (bus.sout_valid !== 1'b1 || bus.sout !== seq[W-1-i]) begin
            failures++;
            $display("FAIL lsb_bit%0d: valid=%b sout=%b required 1 %b", i, bus.sout_valid, bus.sout, seq[W-1-i]);
         end
         // Paired serial-in receiver, LSB-first: new bit enters at the top.
         if (bus.sout_valid === 1'b1) rx = {bus.sout, rx[W-1:1]};
         tick();
      end
      checks++;
      if (rx !== 4'b1011) begin
         failures++;
         $display("FAIL lsb_receiver: got=%b required 1011", rx);
      end
      checks++;
      if (bus.done !== 1'b1) begin
         failures++;
         $display("FAIL lsb_done: done=%b required 1", bus.done);
      end
      tick();
      $display("test_lsb_first word=1011 R_L=1 sent");
   endtask

   task automatic test_ignore_changes();
      logic [W-1:0] seq;
      seq = 4'b0110;
      load_word(4'b0110, 1'b0);
      bus.R_L     = 1'b1;
      bus.data_in = 4'b1111;
      bus.load_valid = 1'b1;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (bus.sout_valid !== 1'b1 || bus.sout !== seq[W-1-i]) begin
            failures++;
            $display("FAIL inflight_bit%0d: valid=%b sout=%b required 1 %b", i, bus.sout_valid, bus.sout, seq[W-1-i]);
         end
         tick();
      end
      bus.load_valid = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.load_ready !== 1'b0) begin
         failures++;
         $display("FAIL inflight_done: done=%b ready=%b required 1 0", bus.done, bus.load_ready);
      end
      tick();
      $display("test_ignore_changes word=0110 unaffected");
   endtask

   task automatic test_async_reset();
      logic [W-1:0] seq;
      int           bad;
      load_word(4'b1100, 1'b0);
      tick();
      checks++;
      if (bus.sout_valid !== 1'b1 || bus.sout !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre_bit: valid=%b sout=%b required 1 1", bus.sout_valid, bus.sout);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.sout !== 1'b0 || bus.sout_valid !== 1'b0 || bus.load_ready !== 1'b1 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL abort_immediate: sout=%b valid=%b ready=%b done=%b required 0 0 1 0",
                  bus.sout, bus.sout_valid, bus.load_ready, bus.done);
      end
      tick();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.sout_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_no_tail: bad_cycles=%0d required 0", bad);
      end
      seq = 4'b0011;
      load_word(4'b0011, 1'b0);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (bus.sout_valid !== 1'b1 || bus.sout !== seq[W-1-i]) begin
            failures++;
            $display("FAIL post_abort_bit%0d: valid=%b sout=%b required 1 %b", i, bus.sout_valid, bus.sout, seq[W-1-i]);
         end
         tick();
      end
      checks++;
      if (bus.done !== 1'b1) begin
         failures++;
         $display("FAIL post_abort_done: done=%b required 1", bus.done);
      end
      tick();
      $display("test_async_reset abort of 1100 then 0011 sent");
   endtask

   task automatic test_back_to_back();
      int           start1, start2, done1, done2, bursts, dones;
      logic         prev_valid;
      logic [W-1:0] rx1, rx2;
      start1 = -1; start2 = -1; done1 = -1; done2 = -1;
      bursts = 0; dones = 0; prev_valid = 1'b0;
      rx1 = '0; rx2 = '0;
      bus.data_in    = 4'hA;
      bus.R_L        = 1'b0;
      bus.load_valid = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) bus.data_in = 4'h5;
         if (k == 7) bus.load_valid = 1'b0;
         if (bus.sout_valid === 1'b1 && prev_valid !== 1'b1) begin
            bursts++;
            if (bursts == 1) start1 = k;
            if (bursts == 2) start2 = k;
         end
         if (bus.sout_valid === 1'b1) begin
            if (bursts == 1) rx1 = {rx1[W-2:0], bus.sout};
            if (bursts == 2) rx2 = {rx2[W-2:0], bus.sout};
         end
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1) done1 = k;
            if (dones == 2) done2 = k;
         end
         prev_valid = bus.sout_valid;
      end
      checks++;
      if (start1 != 1 || start2 - start1 != 6) begin
         failures++;
         $display("FAIL b2b_start_gap: start1=%0d start2=%0d required 1 7", start1, start2);
      end
      checks++;
      if (done1 != 5 || done2 - done1 != 6) begin
         failures++;
         $display("FAIL b2b_done_gap: done1=%0d done2=%0d required 5 11", done1, done2);
      end
      checks++;
      if (rx1 !== 4'hA || rx2 !== 4'h5) begin
         failures++;
         $display("FAIL b2b_words: rx1=%h rx2=%h required a 5", rx1, rx2);
      end
      $display("test_back_to_back words A,5 starts=%0d,%0d", start1, start2);
   endtask

   task automatic test_load_at_reset_release();
      logic [W-1:0] seq;
      seq = 4'b1011;
      rst = 1'b1;
      tick();
      bus.data_in    = 4'b1011;
      bus.R_L        = 1'b0;
      bus.load_valid = 1'b1;
      rst            = 1'b0;
      tick();
      bus.load_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         checks++;
         if (bus.sout_valid !== 1'b1 || bus.sout !== seq[W-1-i]) begin
            failures++;
            $display("FAIL release_bit%0d: valid=%b sout=%b required 1 %b", i, bus.sout_valid, bus.sout, seq[W-1-i]);
         end
         tick();
      end
      checks++;
      if (bus.done !== 1'b1) begin
         failures++;
         $display("FAIL release_done: done=%b required 1", bus.done);
      end
      tick();
      $display("test_load_at_reset_release word=1011 sent");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_ignore_changes();
      test_async_reset();
      test_back_to_back();
      test_load_at_reset_release();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
